// File: rtl/delaychain_meas_ctrl_if.sv
// Request/response bundle between the pin-side controller and the delay-chain
// measurement sequencer, including the chain data input, strobe and observed taps.
interface delaychain_meas_ctrl_if #(
  parameter int N_TAPS = 9,
  parameter int CNT_W  = 12
) ();
  logic              start;
  logic              abort;
  logic [3:0]        tap_sel;
  logic              pol;
  logic [N_TAPS-1:0] taps;
  logic              launch;
  logic              test_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  result;
  logic              timeout;
  logic              error;

  modport master (
    output start, abort, tap_sel, pol, taps,
    input  launch, test_en, busy, done, result, timeout, error
  );

  modport slave (
    input  start, abort, tap_sel, pol, taps,
    output launch, test_en, busy, done, result, timeout, error
  );
endinterface

// File: rtl/delaychain_meas_ctrl.sv
// Delay-chain measurement sequencer: primes the chain, launches one edge and
// counts clk cycles until the selected tap (after a 2-flop synchroniser) follows.
module delaychain_meas_ctrl #(
  parameter int N_TAPS     = 9,
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  delaychain_meas_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRIME   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]       TAP_LIMIT   = 5'(N_TAPS);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [3:0]       tap_sel_q, tap_sel_d;
  logic             pol_q,     pol_d;
  logic             launch_q,  launch_d;
  logic             test_en_q, test_en_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [CNT_W-1:0] result_q,  result_d;
  logic             timeout_q, timeout_d;
  logic             error_q,   error_d;
  logic             sync1_q;
  logic             tap_s_q;
  logic             tap_mux_s;

  always_comb begin
    tap_mux_s = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      tap_mux_s = tap_mux_s | ((tap_sel_q == 4'(i)) & bus.taps[i]);
    end
  end

  // Taps are asynchronous to clk; only the twice-registered tap_s_q is trusted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      tap_s_q <= 1'b0;
    end else begin
      sync1_q <= tap_mux_s;
      tap_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tap_sel_d = tap_sel_q;
    pol_d     = pol_q;
    launch_d  = launch_q;
    test_en_d = test_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    timeout_d = timeout_q;
    error_d   = error_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tap_sel_d = bus.tap_sel;
          pol_d     = bus.pol;
          result_d  = '0;
          timeout_d = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          if ({1'b0, bus.tap_sel} >= TAP_LIMIT) begin
            state_d   = ST_FINISH;
            error_d   = 1'b1;
            done_d    = 1'b1;
            test_en_d = 1'b0;
          end else begin
            state_d   = ST_PRIME;
            launch_d  = ~bus.pol;
            test_en_d = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_PRIME: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          test_en_d = 1'b0;
          busy_d    = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          // A settled non-inverting chain must read back the primed level.
          if (tap_s_q == pol_q) begin
            state_d   = ST_FINISH;
            error_d   = 1'b1;
            done_d    = 1'b1;
            test_en_d = 1'b0;
          end else begin
            state_d  = ST_MEASURE;
            launch_d = pol_q;
            cnt_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_MEASURE: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          test_en_d = 1'b0;
          busy_d    = 1'b0;
        end else if (tap_s_q == pol_q) begin
          state_d   = ST_FINISH;
          result_d  = cnt_q;
          done_d    = 1'b1;
          test_en_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_FINISH;
          result_d  = CNT_MAX;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          test_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_FINISH: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        test_en_d = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        test_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tap_sel_q <= 4'd0;
      pol_q     <= 1'b0;
      launch_q  <= 1'b0;
      test_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tap_sel_q <= tap_sel_d;
      pol_q     <= pol_d;
      launch_q  <= launch_d;
      test_en_q <= test_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
    end
  end

  assign bus.launch  = launch_q;
  assign bus.test_en = test_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.timeout = timeout_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_delaychain_meas_ctrl.sv
// Bench for delaychain_meas_ctrl: taps modelled as D-cycle delay lines of launch,
// a timeline model predicts every output each cycle, directed runs pin literals.
module tb_delaychain_meas_ctrl;

  localparam int NT     = 9;
  localparam int CW     = 6;
  localparam int SETTLE = 50;
  localparam int CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  delaychain_meas_ctrl_if #(.N_TAPS(NT), .CNT_W(CW)) bus ();

  delaychain_meas_ctrl #(.N_TAPS(NT), .CNT_W(CW), .SETTLE_CYC(SETTLE)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Chain model: each tap is launch delayed by tap_d cycles, or stuck at tap_val.
  int          tap_d     [NT];
  bit          tap_stuck [NT];
  bit          tap_val   [NT];
  logic [63:0] lhist = 64'd0;
  logic [NT-1:0] tp;

  always @(posedge clk) lhist <= {lhist[62:0], bus.launch};

  always_comb begin
    tp = '0;
    for (int i = 0; i < NT; i++) begin
      if (tap_stuck[i])     tp[i] = tap_val[i];
      else if (tap_d[i] == 0) tp[i] = bus.launch;
      else                  tp[i] = lhist[tap_d[i] - 1];
    end
  end
  assign bus.taps = tp;

  // Timeline model: cycle k is the interval after the k-th rising edge.
  int   cyc = 0;
  bit   active = 0;
  int   acc_c, e0_c, done_c, res_c, ts;
  bit   ok_c, bad_c, pol_c, to_c, er_c;
  logic e_launch = 1'b0, e_test_en = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic e_to = 1'b0, e_err = 1'b0;
  logic [CW-1:0] e_result = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      active = 0; e_launch = 1'b0; e_test_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_result = '0; e_to = 1'b0; e_err = 1'b0;
    end else if (active && !bad_c && bus.abort && (cyc - 1) < done_c) begin
      active = 0; e_busy = 1'b0; e_test_en = 1'b0;
    end else if (active) begin
      if (ok_c && cyc == e0_c) e_launch = pol_c;
      if (cyc == done_c) begin
        e_done = 1'b1; e_test_en = 1'b0; e_result = CW'(res_c); e_to = to_c; e_err = er_c;
      end
      if (cyc == done_c + 1) begin
        e_done = 1'b0; e_busy = 1'b0; active = 0;
      end
    end else if (bus.start) begin
      pol_c = bus.pol; bad_c = (bus.tap_sel >= 4'(NT));
      acc_c = cyc; e0_c = cyc + SETTLE; res_c = 0; to_c = 0; er_c = 0; ok_c = 0;
      if (bad_c) begin
        done_c = cyc; er_c = 1;
      end else begin
        ts = int'(bus.tap_sel);
        if (tap_stuck[ts]) ok_c = (tap_val[ts] != bus.pol);
        else               ok_c = (tap_d[ts] + 3 <= SETTLE);
        if (!ok_c) begin
          done_c = e0_c; er_c = 1;
        end else if (tap_stuck[ts] || tap_d[ts] + 2 > CMAX) begin
          res_c = CMAX; to_c = 1; done_c = e0_c + 1 + CMAX;
        end else begin
          res_c = tap_d[ts] + 2; done_c = e0_c + 1 + res_c;
        end
      end
      active = 1; e_busy = 1'b1; e_result = '0; e_to = 1'b0; e_err = 1'b0;
      if (bad_c) begin
        e_done = 1'b1; e_err = 1'b1;
      end else begin
        e_launch = ~pol_c; e_test_en = 1'b1;
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("launch",  bus.launch,  e_launch);
      check("test_en", bus.test_en, e_test_en);
      check("busy",    bus.busy,    e_busy);
      check("done",    bus.done,    e_done);
      check("result",  bus.result,  e_result);
      check("timeout", bus.timeout, e_to);
      check("error",   bus.error,   e_err);
    end
  end

  int n;

  task automatic run(input logic [3:0] tsel, input logic p, input logic ab, input int lat,
                     input int res, input logic to, input logic er, input string nm);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.tap_sel = tsel; bus.pol = p; bus.abort = ab;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0; bus.tap_sel = 4'd15; bus.pol = ~p;
    k = 0;
    while (bus.done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
      if (k == 5) begin bus.start = 1'b1; bus.tap_sel = 4'd12; end
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (k >= 300) begin
      failures++; checks++;
      $display("FAIL %s_wait: no done within 300 cycles", nm);
    end else begin
      check({nm, "_lat"}, k, lat);
      check({nm, "_res"}, bus.result, res);
      check({nm, "_to"},  bus.timeout, to);
      check({nm, "_err"}, bus.error, er);
    end
    @(negedge clk);
    check({nm, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.tap_sel = 4'd0; bus.pol = 1'b0;
    for (int i = 0; i < NT; i++) begin
      tap_d[i] = 1; tap_stuck[i] = 0; tap_val[i] = 0;
    end
    tap_d[3] = 0;
    tap_d[8] = 37;
    tap_d[2] = 5;
    tap_stuck[5] = 1; tap_val[5] = 0;
    tap_stuck[6] = 1; tap_val[6] = 0;

    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_launch", bus.launch, 1'b0);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_done",   bus.done,   1'b0);
    check("rst_result", bus.result, 0);
    check("rst_error",  bus.error,  1'b0);
    rst_n = 1'b1;

    run(4'd3,  1'b1, 1'b0, SETTLE + 3,  2,    1'b0, 1'b0, "d0_rise");
    run(4'd8,  1'b0, 1'b1, SETTLE + 40, 39,   1'b0, 1'b0, "d37_fall");
    run(4'd2,  1'b1, 1'b0, SETTLE + 8,  7,    1'b0, 1'b0, "d5_rise");
    run(4'd5,  1'b0, 1'b0, SETTLE,      0,    1'b0, 1'b1, "stuck");
    run(4'd6,  1'b1, 1'b0, SETTLE + 64, CMAX, 1'b1, 1'b0, "tmo");
    run(4'd12, 1'b0, 1'b0, 0,           0,    1'b0, 1'b1, "bad_sel");

    // Abort in MEASURE: idle next cycle, no done afterwards.
    @(negedge clk); bus.start = 1'b1; bus.tap_sel = 4'd8; bus.pol = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (60) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    check("abort_busy",    bus.busy,    1'b0);
    check("abort_test_en", bus.test_en, 1'b0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
    check("abort_no_done", n, 0);

    // Reset in PRIME, then a fresh run.
    @(negedge clk); bus.start = 1'b1; bus.tap_sel = 4'd3; bus.pol = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("prst_busy",    bus.busy,    1'b0);
    check("prst_launch",  bus.launch,  1'b0);
    check("prst_test_en", bus.test_en, 1'b0);
    rst_n = 1'b1;
    run(4'd3, 1'b0, 1'b0, SETTLE + 3, 2, 1'b0, 1'b0, "after_rst");

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
